// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared types and helpers for the UART program loader.
//   - loader_state_t : loader FSM states (IDLE, LOAD, FINISH)
//   - rx_state_t     : UART receiver FSM states
//   - baud_div()     : clock cycles per UART bit, truncating division
package prog_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FINISH
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if
//   Bundles the loader's board-facing signals: the UART line, the load
//   request, the program RAM write port, the CPU hold and the status flags.
//   - slave  : the loader itself (consumes rxd/load_req, drives the rest)
//   - master : whatever sits on the other side (board pins, RAM, CPU, bench)
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int PROG_WIDTH = 8
);
  logic                  rxd;
  logic                  load_req;
  logic                  cpu_hold;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [PROG_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic                  frame_err;

  modport slave (
    input  rxd, load_req,
    output cpu_hold, we, waddr, wdata, busy, done, frame_err
  );

  modport master (
    output rxd, load_req,
    input  cpu_hold, we, waddr, wdata, busy, done, frame_err
  );
endinterface

// File: rtl/prog_loader_uart_rx_core.sv
// uart_rx_core
//   8N1 UART receiver: 2-flop synchronizer, baud counter and receive FSM.
//   Ports:
//     clk, RST        : clock, synchronous active-high reset
//     rxd             : raw asynchronous serial input, idle high
//     enable          : receiver only runs while high; otherwise held idle
//     flush           : drops any frame in progress and returns to idle
//     byte_valid      : one-cycle pulse, byte_data holds the received byte
//     byte_data[7:0]  : last received byte (LSB first on the wire)
//     frame_err_pulse : one-cycle pulse when the stop bit samples low
module uart_rx_core
  import prog_loader_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       rxd,
  input  logic       enable,
  input  logic       flush,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err_pulse
);

  localparam int DIV  = baud_div(CLK_HZ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  logic [1:0] sync_q;
  logic [1:0] sync_d;
  logic       rxd_prev_q;
  logic       rxd_prev_d;
  logic       rxd_s;
  logic       rxd_fall;

  rx_state_t  state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       byte_valid_q;
  logic       frame_err_q;

  // Synchronizer chain; rxd_prev tracks the synchronized line for edge detect.
  always_comb begin
    sync_d     = {sync_q[0], rxd};
    rxd_prev_d = sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      sync_q     <= 2'b11;
      rxd_prev_q <= 1'b1;
    end else begin
      sync_q     <= sync_d;
      rxd_prev_q <= rxd_prev_d;
    end
  end

  assign rxd_s    = sync_q[1];
  assign rxd_fall = rxd_prev_q & ~rxd_s;

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (flush || !enable) begin
        state_q <= RX_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          RX_IDLE: begin
            if (rxd_fall) begin
              state_q <= RX_START;
              cnt_q   <= '0;
            end
          end
          // Re-check the line half a bit in; a short low pulse is a glitch.
          RX_START: begin
            if (cnt_q == HALF_LAST) begin
              cnt_q   <= '0;
              bit_q   <= '0;
              state_q <= rxd_s ? RX_IDLE : RX_DATA;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          RX_DATA: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              shift_q <= {rxd_s, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) state_q <= RX_STOP;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          RX_STOP: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= RX_IDLE;
              if (rxd_s) byte_valid_q <= 1'b1;
              else       frame_err_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign byte_valid      = byte_valid_q;
  assign byte_data       = shift_q;
  assign frame_err_pulse = frame_err_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader
//   Loads a program over UART into the program RAM and holds the CPU in
//   reset until every word has been written.
//   Ports:
//     clk, RST : clock, synchronous active-high reset
//     bus      : prog_loader_if.slave
//                rxd/load_req in; cpu_hold, we/waddr/wdata (RAM write
//                port), busy, done (sticky), frame_err (sticky) out
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int ADDR_WIDTH = 4,
  parameter int PROG_WIDTH = 8
) (
  input logic         clk,
  input logic         RST,
  prog_loader_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err_pulse;
  logic       rx_enable;

  loader_state_t         state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  last_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [PROG_WIDTH-1:0] wdata_q;
  logic                  busy_q;
  logic                  cpu_hold_q;
  logic                  done_q;
  logic                  frame_err_q;

  assign rx_enable = (state_q == LOAD);

  // load_req doubles as the receiver flush so a restart drops partial bytes.
  uart_rx_core #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_rx (
    .clk            (clk),
    .RST            (RST),
    .rxd            (bus.rxd),
    .enable         (rx_enable),
    .flush          (bus.load_req),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .frame_err_pulse(frame_err_pulse)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_q      <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      // A load request starts or restarts from any state and beats a
      // byte_valid arriving in the same cycle.
      if (bus.load_req) begin
        state_q     <= LOAD;
        ptr_q       <= '0;
        last_q      <= 1'b0;
        waddr_q     <= '0;
        busy_q      <= 1'b1;
        cpu_hold_q  <= 1'b1;
        done_q      <= 1'b0;
        frame_err_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          LOAD: begin
            // last_q marks the cycle of the final write; leaving LOAD only
            // afterwards keeps we confined to LOAD.
            if (last_q) begin
              state_q <= FINISH;
              last_q  <= 1'b0;
            end else begin
              if (frame_err_pulse) frame_err_q <= 1'b1;
              if (byte_valid) begin
                we_q    <= 1'b1;
                wdata_q <= PROG_WIDTH'(byte_data);
                waddr_q <= ptr_q;
                if (ptr_q == LAST_ADDR) last_q <= 1'b1;
                else                    ptr_q  <= ptr_q + 1'b1;
              end
            end
          end
          FINISH: begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b1;
            waddr_q    <= '0;
            ptr_q      <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.done      = done_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Self-checking bench for prog_loader. Bytes are sent as 8N1 frames at
//   16 clocks per bit; a monitor logs every RAM write and the model derives
//   the expected write list from the transmitted byte list.
module tb_prog_loader;

  localparam int BAUD   = 9600;
  localparam int CLK_HZ = 16 * BAUD;
  localparam int AW     = 4;
  localparam int PW     = 8;
  localparam int DEPTH  = 1 << AW;
  localparam int BIT    = CLK_HZ / BAUD;

  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_WIDTH(AW), .PROG_WIDTH(PW)) bus ();

  prog_loader #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .ADDR_WIDTH(AW),
    .PROG_WIDTH(PW)
  ) dut (
    .clk(clk),
    .RST(RST),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int addr;
    int data;
    int at;
  } wr_t;
  wr_t wq[$];

  logic hold_prev = 1'b0;
  int   hold_fall_at = -1;
  int   hold_drops = 0;

  logic [7:0] tx_b[$];
  bit         tx_ok[$];
  int         exp_a[$];
  int         exp_d[$];
  bit         exp_ferr;
  bit         exp_done;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log writes and cpu_hold falling edges, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.we === 1'b1)
      wq.push_back('{addr: int'(bus.waddr), data: int'(bus.wdata), at: cyc});
    if (hold_prev === 1'b1 && bus.cpu_hold === 1'b0) begin
      hold_fall_at <= cyc;
      hold_drops   <= hold_drops + 1;
    end
    hold_prev <= bus.cpu_hold;
  end

  // Reference: bytes with a good stop bit fill addresses 0.. in order until
  // the memory is full; a bad stop bit only raises frame_err.
  function automatic void build_model();
    int ptr;
    ptr = 0;
    exp_a.delete();
    exp_d.delete();
    exp_ferr = 1'b0;
    foreach (tx_b[i]) begin
      if (!tx_ok[i]) exp_ferr = 1'b1;
      else if (ptr < DEPTH) begin
        exp_a.push_back(ptr);
        exp_d.push_back(int'(tx_b[i]));
        ptr++;
      end
    end
    exp_done = (ptr == DEPTH);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load();
    bus.load_req = 1'b1;
    @(negedge clk);
    bus.load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] frame;
    frame = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rxd = frame[i];
      repeat (BIT) @(negedge clk);
    end
    bus.rxd = 1'b1;
  endtask

  task automatic send_list();
    foreach (tx_b[i]) begin
      send_byte(tx_b[i], tx_ok[i]);
      if (tx_ok[i]) idle(int'($urandom_range(2, 12)));
      else          idle(BIT + int'($urandom_range(2, 12)));
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge clk);
    checks += 7;
    if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_cpu_hold: got %b expected 0", bus.cpu_hold); end
    if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.we); end
    if (bus.waddr !== '0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", bus.waddr); end
    if (bus.wdata !== '0) begin errors++; $display("FAIL reset_wdata: got %02h expected 00", bus.wdata); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
    RST = 1'b0;
    idle(2);
    $display("reset: outputs checked");
  endtask

  task automatic test_full_load();
    int base, t;
    base = wq.size();
    pulse_load();
    checks += 2;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b expected 1", bus.busy); end
    if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL full_hold: got %b expected 1", bus.cpu_hold); end
    tx_b.delete(); tx_ok.delete();
    for (int i = 0; i < DEPTH; i++) begin tx_b.push_back(8'(8'h10 + i)); tx_ok.push_back(1'b1); end
    build_model();
    send_list();
    t = 0;
    while (wq.size() - base < exp_a.size() && t < 4000) begin @(negedge clk); t++; end
    idle(10);
    checks++;
    if (wq.size() - base !== exp_a.size()) begin errors++; $display("FAIL full_count: got %0d writes expected %0d", wq.size() - base, exp_a.size()); end
    for (int i = 0; i < exp_a.size() && base + i < wq.size(); i++) begin
      checks++;
      if (wq[base+i].addr !== exp_a[i] || wq[base+i].data !== exp_d[i]) begin
        errors++;
        $display("FAIL full_wr%0d: got addr %0d data %02h expected addr %0d data %02h", i, wq[base+i].addr, wq[base+i].data, exp_a[i], exp_d[i]);
      end
    end
    checks += 4;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL full_done: got %b expected 1", bus.done); end
    if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL full_hold_end: got %b expected 0", bus.cpu_hold); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL full_busy_end: got %b expected 0", bus.busy); end
    if (wq.size() > 0 && hold_fall_at - wq[$].at !== 2) begin
      errors++; $display("FAIL full_hold_latency: got %0d cycles expected 2", hold_fall_at - wq[$].at);
    end
    $display("full_load: %0d writes", wq.size() - base);
  endtask

  task automatic test_frame_err();
    int base;
    base = wq.size();
    pulse_load();
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL ferr_done_clear: got %b expected 0", bus.done); end
    tx_b.delete(); tx_ok.delete();
    tx_b.push_back(8'hA5); tx_ok.push_back(1'b0);
    tx_b.push_back(8'h3C); tx_ok.push_back(1'b1);
    build_model();
    send_list();
    idle(10);
    checks += 3;
    if (bus.frame_err !== exp_ferr) begin errors++; $display("FAIL ferr_flag: got %b expected %b", bus.frame_err, exp_ferr); end
    if (wq.size() - base !== 1) begin errors++; $display("FAIL ferr_count: got %0d writes expected 1", wq.size() - base); end
    else if (wq[base].addr !== exp_a[0] || wq[base].data !== exp_d[0]) begin
      errors++; $display("FAIL ferr_wr: got addr %0d data %02h expected addr %0d data %02h", wq[base].addr, wq[base].data, exp_a[0], exp_d[0]);
    end
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL ferr_busy: got %b expected 1", bus.busy); end
    $display("frame_err: flag %b, %0d writes", bus.frame_err, wq.size() - base);
  endtask

  task automatic test_glitch();
    int base;
    base = wq.size();
    pulse_load();
    checks++;
    if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL glitch_ferr_clear: got %b expected 0", bus.frame_err); end
    bus.rxd = 1'b0;
    idle(4);
    bus.rxd = 1'b1;
    idle(3 * BIT);
    send_byte(8'h7E, 1'b1);
    idle(10);
    checks += 2;
    if (wq.size() - base !== 1) begin errors++; $display("FAIL glitch_count: got %0d writes expected 1", wq.size() - base); end
    else if (wq[base].addr !== 0 || wq[base].data !== 8'h7E) begin
      errors++; $display("FAIL glitch_wr: got addr %0d data %02h expected addr 0 data 7e", wq[base].addr, wq[base].data);
    end
    if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL glitch_ferr: got %b expected 0", bus.frame_err); end
    $display("glitch: %0d writes", wq.size() - base);
  endtask

  task automatic test_random_frames();
    int base, good, t;
    base = wq.size();
    pulse_load();
    tx_b.delete(); tx_ok.delete();
    good = 0;
    while (good < DEPTH) begin
      tx_b.push_back(8'($urandom_range(0, 255)));
      if (good > 0 && $urandom_range(0, 3) == 0) tx_ok.push_back(1'b0);
      else begin tx_ok.push_back(1'b1); good++; end
    end
    build_model();
    send_list();
    t = 0;
    while (wq.size() - base < exp_a.size() && t < 4000) begin @(negedge clk); t++; end
    idle(10);
    checks++;
    if (wq.size() - base !== exp_a.size()) begin errors++; $display("FAIL rand_count: got %0d writes expected %0d", wq.size() - base, exp_a.size()); end
    for (int i = 0; i < exp_a.size() && base + i < wq.size(); i++) begin
      checks++;
      if (wq[base+i].addr !== exp_a[i] || wq[base+i].data !== exp_d[i]) begin
        errors++;
        $display("FAIL rand_wr%0d: got addr %0d data %02h expected addr %0d data %02h", i, wq[base+i].addr, wq[base+i].data, exp_a[i], exp_d[i]);
      end
    end
    checks += 2;
    if (bus.frame_err !== exp_ferr) begin errors++; $display("FAIL rand_ferr: got %b expected %b", bus.frame_err, exp_ferr); end
    if (bus.done !== exp_done) begin errors++; $display("FAIL rand_done: got %b expected %b", bus.done, exp_done); end
    $display("random_frames: %0d frames sent, %0d writes", tx_b.size(), wq.size() - base);
  endtask

  task automatic test_restart();
    int base, drops0, t;
    logic [7:0] partial;
    base = wq.size();
    pulse_load();
    tx_b.delete(); tx_ok.delete();
    for (int i = 0; i < 5; i++) begin tx_b.push_back(8'($urandom_range(0, 255))); tx_ok.push_back(1'b1); end
    build_model();
    send_list();
    checks++;
    if (wq.size() - base !== 5) begin errors++; $display("FAIL restart_pre_count: got %0d writes expected 5", wq.size() - base); end
    // Cut a frame off in its data bits with a fresh load request.
    drops0 = hold_drops;
    partial = 8'($urandom_range(0, 255));
    bus.rxd = 1'b0;
    idle(BIT);
    for (int i = 0; i < 3; i++) begin bus.rxd = partial[i]; idle(BIT); end
    bus.rxd = partial[3];
    idle(BIT / 2);
    base = wq.size();
    pulse_load();
    bus.rxd = 1'b1;
    idle(3 * BIT);
    tx_b.delete(); tx_ok.delete();
    for (int i = 0; i < DEPTH; i++) begin tx_b.push_back(8'(8'hF0 + i)); tx_ok.push_back(1'b1); end
    build_model();
    send_list();
    t = 0;
    while (wq.size() - base < exp_a.size() && t < 4000) begin @(negedge clk); t++; end
    idle(10);
    checks++;
    if (wq.size() - base !== exp_a.size()) begin errors++; $display("FAIL restart_count: got %0d writes expected %0d", wq.size() - base, exp_a.size()); end
    for (int i = 0; i < exp_a.size() && base + i < wq.size(); i++) begin
      checks++;
      if (wq[base+i].addr !== exp_a[i] || wq[base+i].data !== exp_d[i]) begin
        errors++;
        $display("FAIL restart_wr%0d: got addr %0d data %02h expected addr %0d data %02h", i, wq[base+i].addr, wq[base+i].data, exp_a[i], exp_d[i]);
      end
    end
    checks += 3;
    if (hold_drops - drops0 !== 1) begin errors++; $display("FAIL restart_hold_drops: got %0d expected 1", hold_drops - drops0); end
    if (wq.size() > 0 && hold_fall_at - wq[$].at !== 2) begin
      errors++; $display("FAIL restart_hold_latency: got %0d cycles expected 2", hold_fall_at - wq[$].at);
    end
    if (bus.done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b expected 1", bus.done); end
    $display("restart: %0d writes after restart", wq.size() - base);
  endtask

  task automatic test_idle_and_rst();
    int base, t;
    base = wq.size();
    send_byte(8'h55, 1'b1);
    idle(20);
    checks += 2;
    if (wq.size() - base !== 0) begin errors++; $display("FAIL idle_no_write: got %0d writes expected 0", wq.size() - base); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    pulse_load();
    tx_b.delete(); tx_ok.delete();
    for (int i = 0; i < 3; i++) begin tx_b.push_back(8'($urandom_range(0, 255))); tx_ok.push_back(1'b1); end
    build_model();
    send_list();
    t = 0;
    while (wq.size() - base < 3 && t < 2000) begin @(negedge clk); t++; end
    checks++;
    if (wq.size() - base !== 3) begin errors++; $display("FAIL rst_pre_count: got %0d writes expected 3", wq.size() - base); end
    for (int i = 0; i < 3 && base + i < wq.size(); i++) begin
      checks++;
      if (wq[base+i].addr !== exp_a[i] || wq[base+i].data !== exp_d[i]) begin
        errors++;
        $display("FAIL rst_wr%0d: got addr %0d data %02h expected addr %0d data %02h", i, wq[base+i].addr, wq[base+i].data, exp_a[i], exp_d[i]);
      end
    end
    RST = 1'b1;
    @(negedge clk);
    checks += 7;
    if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b expected 0", bus.cpu_hold); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", bus.done); end
    if (bus.we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", bus.we); end
    if (bus.waddr !== '0) begin errors++; $display("FAIL rst_waddr: got %0d expected 0", bus.waddr); end
    if (bus.wdata !== '0) begin errors++; $display("FAIL rst_wdata: got %02h expected 00", bus.wdata); end
    if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b expected 0", bus.frame_err); end
    RST = 1'b0;
    idle(2);
    $display("idle_and_rst: mid-load reset checked");
  endtask

  initial begin
    bus.rxd      = 1'b1;
    bus.load_req = 1'b0;
    test_reset();
    test_full_load();
    test_frame_err();
    test_glitch();
    test_random_frames();
    test_restart();
    test_idle_and_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the program memory: receives program bytes over an 8N1 UART line and writes them sequentially into the 16-entry program RAM.
- The CPU fetches from this same RAM.
- Holds the CPU in reset while loading and releases it once all 2^ADDR_WIDTH words are written.
- Sits between the board UART pin, the program RAM write port and the CPU reset input.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- BAUD, 9600, UART bit rate.
- ADDR_WIDTH, 4, program address width; depth = 2^ADDR_WIDTH.
- PROG_WIDTH, 8, program word width (op[7:4], im[3:0]).

Ports:
- clk, input, 1, system clock (undivided board clock).
- RST, input, 1, reset; synchronous, active-high.
- rxd, input, 1, asynchronous UART serial input; idle high.
- load_req, input, 1, single-cycle pulse that starts (or restarts) a load.
- cpu_hold, output, 1, drives the CPU reset while loading.
- we, output, 1, program RAM write enable; one-cycle pulse per word.
- waddr, output, ADDR_WIDTH, program RAM write address.
- wdata, output, PROG_WIDTH, program RAM write data.
- busy, output, 1, high while a load is in progress.
- done, output, 1, sticky; set when the last word is written, cleared by load_req or RST.
- frame_err, output, 1, sticky; set on a bad stop bit, cleared by load_req or RST.

Behaviour:
- Reset values: cpu_hold=0, we=0, waddr=0, wdata=0, busy=0, done=0, frame_err=0. Loader FSM in IDLE, receiver in RX_IDLE, rxd synchronizer set to 1.
- rxd passes through a 2-flop synchronizer before use. All sampling uses the synchronized value.
- DIV = CLK_HZ/BAUD (integer division), HALF = DIV/2, computed at elaboration. A bit counter runs 0..DIV-1.
- Receiver FSM:
  - RX_IDLE: on a falling edge of synchronized rxd, go to RX_START.
  - RX_START: wait HALF cycles, then re-sample rxd. If 1 (glitch), return to RX_IDLE. If 0, go to RX_DATA.
  - RX_DATA: sample every DIV cycles; 8 bits, LSB first, into a shift register.
  - RX_STOP: sample after DIV cycles. If 1, emit byte_valid for one cycle. If 0, set frame_err, discard the byte, go to RX_IDLE.
- The receiver ignores rxd unless busy=1. Bytes arriving while busy=0 are dropped silently.
- Loader FSM:
  - IDLE: on load_req, go to LOAD. Set busy=1 and cpu_hold=1, clear done and frame_err, set waddr=0.
  - LOAD: on byte_valid, in the next cycle drive wdata=byte, we=1, waddr=current pointer.
    - If the pointer equals 2^ADDR_WIDTH-1, go to FINISH.
    - Otherwise the pointer increments after the write.
  - FINISH: one cycle with we=0. Then busy=0, cpu_hold=0, done=1, waddr=0; return to IDLE.
- Latency: the we pulse occurs exactly 1 cycle after byte_valid. cpu_hold falls exactly 2 cycles after the final we.
- load_req while in LOAD: restart. Pointer returns to 0, receiver returns to RX_IDLE (any partial byte is discarded), frame_err and done are cleared. cpu_hold stays high continuously.
- load_req in the same cycle as byte_valid: the restart wins and that byte is not written.
- frame_err does not abort the load. The pointer does not advance; the next valid byte goes to the same address.
- Pointer wrap: never occurs. The load ends at the last address and FINISH resets waddr to 0.
- RST asserted mid-load: every output returns to its reset value on the next clock. cpu_hold=0 there; the top level ORs RST into the CPU reset anyway.
- wdata holds the last written value between writes. we is never high outside LOAD.

Decomposition:
- Shared package prog_loader_pkg holds:
  - loader_state_t enum {IDLE, LOAD, FINISH}.
  - rx_state_t enum {RX_IDLE, RX_START, RX_DATA, RX_STOP}.
  - function baud_div(CLK_HZ, BAUD).
- One sub-module, uart_rx_core: synchronizer, baud counter, receiver FSM.
  - Inputs: clk, RST, rxd, enable, flush.
  - Outputs: byte_valid, byte_data[7:0], frame_err_pulse.
- prog_loader keeps the loader FSM, address pointer and sticky flags.

Test Plan:
- Use CLK_HZ=16*BAUD for simulation, so DIV=16.
- Reset: assert RST for 3 cycles. Expect all outputs 0, waddr=0.
- Full load: pulse load_req, send bytes 0x10..0x1F. Expect 16 we pulses with waddr 0..15 and wdata 0x10..0x1F. Expect done=1 and cpu_hold=0 two cycles after the last we.
- Framing error: pulse load_req, send 0xA5 with stop bit 0, then 0x3C valid. Expect frame_err=1, no write for 0xA5, and 0x3C written at waddr=0.
- Glitch rejection: pulse load_req, drive a 4-cycle low pulse on rxd, then send 0x7E. Expect exactly one write, wdata=0x7E at waddr=0.
- Restart mid-load: after 5 bytes are written, pulse load_req during a byte's data bits, then send 16 bytes 0xF0..0xFF. Expect the first new write at waddr=0 with wdata=0xF0, and cpu_hold high throughout.
- Idle and reset-mid-load:
  - Send 0x55 with busy=0. Expect no we.
  - Then pulse load_req, send 3 bytes, assert RST. Expect cpu_hold=0, busy=0, done=0 on the next edge.
